// File: rtl/vga_mem_arbiter_if.sv
// Bus bundle between the VGA SRAM arbiter and its video, CPU and SRAM neighbours.
// slave = arbiter side, master = environment side (display, Wishbone CPU, SRAM).
interface vga_mem_arbiter_if;
  logic        vid_frame_start;
  logic        vid_pop;
  logic [15:0] vid_data;
  logic        vid_valid;
  logic        vid_underrun;

  logic        cpu_cyc;
  logic        cpu_stb;
  logic        cpu_we;
  logic [17:0] cpu_adr;
  logic [1:0]  cpu_sel;
  logic [15:0] cpu_dat_i;
  logic [15:0] cpu_dat_o;
  logic        cpu_ack;

  logic        mem_en;
  logic        mem_we;
  logic [1:0]  mem_sel;
  logic [17:0] mem_adr;
  logic [15:0] mem_dat_o;
  logic [15:0] mem_dat_i;

  modport slave (
    input  vid_frame_start, vid_pop,
    output vid_data, vid_valid, vid_underrun,
    input  cpu_cyc, cpu_stb, cpu_we, cpu_adr, cpu_sel, cpu_dat_i,
    output cpu_dat_o, cpu_ack,
    output mem_en, mem_we, mem_sel, mem_adr, mem_dat_o,
    input  mem_dat_i
  );

  modport master (
    output vid_frame_start, vid_pop,
    input  vid_data, vid_valid, vid_underrun,
    output cpu_cyc, cpu_stb, cpu_we, cpu_adr, cpu_sel, cpu_dat_i,
    input  cpu_dat_o, cpu_ack,
    input  mem_en, mem_we, mem_sel, mem_adr, mem_dat_o,
    output mem_dat_i
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Single-port SRAM arbiter: video prefetch FIFO vs Wishbone CPU, one access per cycle,
// issue in cycle N / data+ack in N+1; video refill is throttled by FIFO occupancy.
module vga_mem_arbiter_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       rst_i,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       nonempty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign nonempty = (count != '0);
  assign pop_ok   = pop && nonempty;
  // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
  assign push_ok  = push && ((count != FULL_CNT) || pop_ok);
  assign pop_dat  = nonempty ? store[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (push_ok && !flush) begin
      store[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clock or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

module vga_mem_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int URGENT_LEVEL = 2,
  parameter int FRAME_WORDS  = 153600
) (
  input  logic             clock,
  input  logic             rst_i,
  vga_mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] URGENT_L = URGENT_LEVEL[CNT_W:0];
  localparam logic [CNT_W:0] DEPTH_L  = FIFO_DEPTH[CNT_W:0];
  localparam logic [17:0]    LAST_ADR = 18'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VID  = 2'd1,
    S_CPU  = 2'd2
  } state_t;

  state_t           state;
  logic [17:0]      vid_adr;
  logic             underrun;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   level;
  logic             fifo_nonempty;
  logic [15:0]      fifo_head;
  logic             fifo_push;
  logic             fifo_pop;
  logic             cpu_req;
  logic             vid_allowed;
  logic             grant_vid;
  logic             grant_cpu;

  // Occupancy counts the read already in flight so the FIFO can never be oversubscribed.
  assign level       = {1'b0, fifo_cnt} + (CNT_W + 1)'(state == S_VID);
  assign cpu_req     = bus.cpu_cyc && bus.cpu_stb && (state != S_CPU);
  assign vid_allowed = rst_i && !bus.vid_frame_start;

  always_comb begin
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    if (vid_allowed && (level < URGENT_L)) begin
      grant_vid = 1'b1;
    end else if (rst_i && cpu_req) begin
      grant_cpu = 1'b1;
    end else if (vid_allowed && (level < DEPTH_L)) begin
      grant_vid = 1'b1;
    end
  end

  always_comb begin
    bus.mem_en    = grant_vid || grant_cpu;
    bus.mem_we    = grant_cpu && bus.cpu_we;
    bus.mem_sel   = 2'b00;
    bus.mem_adr   = '0;
    bus.mem_dat_o = '0;
    if (grant_vid) begin
      bus.mem_sel = 2'b11;
      bus.mem_adr = vid_adr;
    end else if (grant_cpu) begin
      bus.mem_sel   = bus.cpu_sel;
      bus.mem_adr   = bus.cpu_adr;
      bus.mem_dat_o = bus.cpu_dat_i;
    end
  end

  assign bus.cpu_ack      = (state == S_CPU);
  assign bus.cpu_dat_o    = (state == S_CPU) ? bus.mem_dat_i : '0;
  assign bus.vid_valid    = fifo_nonempty;
  assign bus.vid_data     = fifo_head;
  assign bus.vid_underrun = underrun;

  // Frame start discards the returning video word and any pop in the same cycle.
  assign fifo_push = (state == S_VID) && !bus.vid_frame_start;
  assign fifo_pop  = bus.vid_pop && !bus.vid_frame_start;

  vga_mem_arbiter_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .rst_i    (rst_i),
    .flush    (bus.vid_frame_start),
    .push     (fifo_push),
    .push_dat (bus.mem_dat_i),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .count    (fifo_cnt),
    .nonempty (fifo_nonempty)
  );

  always_ff @(posedge clock or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      vid_adr  <= '0;
      underrun <= 1'b0;
    end else begin
      if (grant_vid)      state <= S_VID;
      else if (grant_cpu) state <= S_CPU;
      else                state <= S_IDLE;

      if (bus.vid_frame_start) begin
        vid_adr <= '0;
      end else if (grant_vid) begin
        vid_adr <= (vid_adr == LAST_ADR) ? '0 : vid_adr + 18'd1;
      end

      if (bus.vid_pop && !fifo_nonempty && !bus.vid_frame_start) begin
        underrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter with a one-cycle-latency SRAM model;
// a short frame (8 words) makes the video address wrap reachable.
`define CHK(tag, obs, exp) check(tag, 32'(obs), 32'(exp))

module tb_vga_mem_arbiter;
  logic clock;
  logic rst_i;
  int   checks;
  int   errors;

  vga_mem_arbiter_if bus ();

  vga_mem_arbiter #(
    .FIFO_DEPTH   (4),
    .URGENT_LEVEL (2),
    .FRAME_WORDS  (8)
  ) dut (
    .clock (clock),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] sram_word(input logic [17:0] adr);
    if (adr == 18'h00100) return 16'hBEEF;
    return adr[15:0] ^ 16'h5A00;
  endfunction

  always @(posedge clock) begin
    if (bus.mem_en && !bus.mem_we) bus.mem_dat_i <= sram_word(bus.mem_adr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_check(input string tag, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s at %0t", tag, $time);
    end
  endtask

  always @(negedge clock) begin
    if (bus.mem_en === 1'b0) begin
      mon_check("mon_idle_no_we", bus.mem_we === 1'b0);
    end
    if (bus.cpu_ack === 1'b1 && bus.mem_en === 1'b1) begin
      mon_check("mon_ack_no_cpu_regrant", (bus.mem_sel === 2'b11) && (bus.mem_we === 1'b0));
    end
    if (bus.vid_valid === 1'b0) begin
      mon_check("mon_empty_data_zero", bus.vid_data === 16'h0000);
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_i = 1'b0;
    bus.vid_frame_start = 1'b0;
    bus.vid_pop   = 1'b0;
    bus.cpu_cyc   = 1'b0;
    bus.cpu_stb   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_adr   = '0;
    bus.cpu_sel   = 2'b00;
    bus.cpu_dat_i = '0;
    bus.mem_dat_i = '0;

    // Held in reset
    next_cycle(); next_cycle(); mid();
    `CHK("rst_mem_en", bus.mem_en, 1'b0);
    `CHK("rst_mem_we", bus.mem_we, 1'b0);
    `CHK("rst_vid_valid", bus.vid_valid, 1'b0);
    `CHK("rst_underrun", bus.vid_underrun, 1'b0);
    `CHK("rst_cpu_ack", bus.cpu_ack, 1'b0);
    `CHK("rst_cpu_dat", bus.cpu_dat_o, 16'h0000);
    `CHK("rst_vid_data", bus.vid_data, 16'h0000);

    // Release: four video reads 0..3, then idle with a full FIFO
    next_cycle(); rst_i = 1'b1; mid();
    `CHK("fill0_en", bus.mem_en, 1'b1);
    `CHK("fill0_adr", bus.mem_adr, 18'd0);
    `CHK("fill0_sel", bus.mem_sel, 2'b11);
    `CHK("fill0_we", bus.mem_we, 1'b0);
    `CHK("fill0_valid", bus.vid_valid, 1'b0);
    for (int i = 1; i < 4; i++) begin
      next_cycle(); mid();
      `CHK("fill_en", bus.mem_en, 1'b1);
      `CHK("fill_adr", bus.mem_adr, 18'(i));
      `CHK("fill_valid", bus.vid_valid, (i >= 2));
    end
    `CHK("fill_head", bus.vid_data, 16'h5A00);
    next_cycle(); mid();
    `CHK("full_idle4", bus.mem_en, 1'b0);
    next_cycle(); mid();
    `CHK("full_idle5", bus.mem_en, 1'b0);

    // CPU read with full FIFO
    next_cycle();
    bus.cpu_cyc = 1'b1; bus.cpu_stb = 1'b1; bus.cpu_we = 1'b0;
    bus.cpu_adr = 18'h00100; bus.cpu_sel = 2'b11;
    mid();
    `CHK("cpurd_en", bus.mem_en, 1'b1);
    `CHK("cpurd_we", bus.mem_we, 1'b0);
    `CHK("cpurd_adr", bus.mem_adr, 18'h00100);
    next_cycle(); mid();
    `CHK("cpurd_ack", bus.cpu_ack, 1'b1);
    `CHK("cpurd_dat", bus.cpu_dat_o, 16'hBEEF);
    `CHK("cpurd_noregrant", bus.mem_en, 1'b0);
    next_cycle(); bus.cpu_cyc = 1'b0; bus.cpu_stb = 1'b0; mid();
    `CHK("cpurd_ack_once", bus.cpu_ack, 1'b0);
    `CHK("cpurd_novid", bus.mem_en, 1'b0);

    // CPU byte-lane write
    next_cycle();
    bus.cpu_cyc = 1'b1; bus.cpu_stb = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_adr = 18'h00200; bus.cpu_sel = 2'b10; bus.cpu_dat_i = 16'h1234;
    mid();
    `CHK("cpuwr_en", bus.mem_en, 1'b1);
    `CHK("cpuwr_we", bus.mem_we, 1'b1);
    `CHK("cpuwr_sel", bus.mem_sel, 2'b10);
    `CHK("cpuwr_dat", bus.mem_dat_o, 16'h1234);
    `CHK("cpuwr_adr", bus.mem_adr, 18'h00200);
    next_cycle(); mid();
    `CHK("cpuwr_ack", bus.cpu_ack, 1'b1);
    `CHK("cpuwr_idle", bus.mem_en, 1'b0);
    next_cycle(); bus.cpu_cyc = 1'b0; bus.cpu_stb = 1'b0; bus.cpu_we = 1'b0; mid();
    `CHK("cpuwr_ack_once", bus.cpu_ack, 1'b0);

    // Pop frees a slot: one refill at address 4
    next_cycle(); bus.vid_pop = 1'b1; mid();
    `CHK("pop1_head", bus.vid_data, 16'h5A00);
    `CHK("pop1_nogrant", bus.mem_en, 1'b0);
    next_cycle(); bus.vid_pop = 1'b0; mid();
    `CHK("refill_head", bus.vid_data, 16'h5A01);
    `CHK("refill_en", bus.mem_en, 1'b1);
    `CHK("refill_adr", bus.mem_adr, 18'd4);
    next_cycle(); mid();
    `CHK("refill_done", bus.mem_en, 1'b0);

    // Frame start while a video read (address 5) is in flight
    next_cycle(); bus.vid_pop = 1'b1; mid();
    `CHK("pop2_head", bus.vid_data, 16'h5A01);
    next_cycle(); bus.vid_pop = 1'b0; mid();
    `CHK("fs_pre_adr", bus.mem_adr, 18'd5);
    next_cycle(); bus.vid_frame_start = 1'b1; bus.vid_pop = 1'b1; mid();
    `CHK("fs_no_vid_grant", bus.mem_en, 1'b0);
    next_cycle(); bus.vid_frame_start = 1'b0; bus.vid_pop = 1'b0; mid();
    `CHK("fs_empty", bus.vid_valid, 1'b0);
    `CHK("fs_data0", bus.vid_data, 16'h0000);
    `CHK("fs_adr0", bus.mem_adr, 18'd0);
    `CHK("fs_en", bus.mem_en, 1'b1);
    `CHK("fs_no_underrun", bus.vid_underrun, 1'b0);
    next_cycle(); mid();
    `CHK("fs_still_empty", bus.vid_valid, 1'b0);
    `CHK("fs_adr1", bus.mem_adr, 18'd1);
    next_cycle(); mid();
    `CHK("fs_first_word", bus.vid_data, 16'h5A00);
    `CHK("fs_adr2", bus.mem_adr, 18'd2);
    next_cycle(); mid();
    `CHK("fs_adr3", bus.mem_adr, 18'd3);
    next_cycle(); mid();

    // Frame start with CPU pending, then continuous CPU load with a pop every 2 cycles
    next_cycle();
    bus.vid_frame_start = 1'b1;
    bus.cpu_cyc = 1'b1; bus.cpu_stb = 1'b1; bus.cpu_we = 1'b0;
    bus.cpu_adr = 18'h00300; bus.cpu_sel = 2'b11;
    mid();
    `CHK("load_cpu_adr", bus.mem_adr, 18'h00300);
    `CHK("load_cpu_en", bus.mem_en, 1'b1);
    next_cycle(); bus.vid_frame_start = 1'b0; mid();
    `CHK("load_ack0", bus.cpu_ack, 1'b1);
    `CHK("load_dat0", bus.cpu_dat_o, 16'h5900);
    `CHK("load_urgent0", bus.mem_adr, 18'd0);
    next_cycle(); mid();
    `CHK("load_urgent1_ack", bus.cpu_ack, 1'b0);
    `CHK("load_urgent1", bus.mem_adr, 18'd1);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); bus.vid_pop = 1'b1; mid();
      `CHK("alt_cpu_adr", bus.mem_adr, 18'h00300);
      `CHK("alt_cpu_we", bus.mem_we, 1'b0);
      `CHK("alt_noack", bus.cpu_ack, 1'b0);
      `CHK("alt_head", bus.vid_data, 16'h5A00 + 16'(k));
      next_cycle(); bus.vid_pop = 1'b0; mid();
      `CHK("alt_ack", bus.cpu_ack, 1'b1);
      `CHK("alt_dat", bus.cpu_dat_o, 16'h5900);
      `CHK("alt_vid_adr", bus.mem_adr, 18'(2 + k));
    end
    `CHK("alt_no_underrun", bus.vid_underrun, 1'b0);

    // Video address wraps 7 -> 0
    next_cycle(); bus.cpu_cyc = 1'b0; bus.cpu_stb = 1'b0; mid();
    `CHK("wrap_adr6", bus.mem_adr, 18'd6);
    next_cycle(); mid();
    `CHK("wrap_adr7", bus.mem_adr, 18'd7);
    next_cycle(); mid();
    `CHK("wrap_full", bus.mem_en, 1'b0);
    next_cycle(); bus.vid_pop = 1'b1; mid();
    next_cycle(); bus.vid_pop = 1'b0; mid();
    `CHK("wrap_en", bus.mem_en, 1'b1);
    `CHK("wrap_adr0", bus.mem_adr, 18'd0);

    // Underrun is sticky across frame start
    next_cycle(); bus.vid_frame_start = 1'b1; mid();
    next_cycle(); bus.vid_frame_start = 1'b0; bus.vid_pop = 1'b1; mid();
    `CHK("ur_empty", bus.vid_valid, 1'b0);
    `CHK("ur_adr0", bus.mem_adr, 18'd0);
    next_cycle(); bus.vid_pop = 1'b0; mid();
    `CHK("ur_set", bus.vid_underrun, 1'b1);
    next_cycle(); bus.vid_frame_start = 1'b1; mid();
    next_cycle(); bus.vid_frame_start = 1'b0; mid();
    `CHK("ur_sticky", bus.vid_underrun, 1'b1);

    // Asynchronous reset mid-cycle
    next_cycle(); rst_i = 1'b0; #1;
    `CHK("arst_underrun", bus.vid_underrun, 1'b0);
    `CHK("arst_mem_en", bus.mem_en, 1'b0);
    `CHK("arst_valid", bus.vid_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
